// File: rtl/relu_maxpool_col.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool_col
// Brief    : ReLU + 2x2/stride-2 max pool + rescale/saturate over conv columns,
//            one pooled column per input column pair on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool_col #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_ROWS   = 25,
  parameter int NUM_COLS   = 25,
  parameter int FRAC_SHIFT = 8,
  localparam int c_out_rows = NUM_ROWS / 2,
  localparam int c_out_cols = NUM_COLS / 2,
  localparam int c_col_w    = $clog2(c_out_cols) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data [NUM_ROWS-1:0],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data [c_out_rows-1:0],
  output logic [c_col_w-1:0]   out_col,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int c_cnt_w = $clog2(NUM_COLS) + 1;
  localparam logic [c_cnt_w-1:0]  c_last_col  = c_cnt_w'(NUM_COLS - 1);
  localparam logic [c_cnt_w-1:0]  c_last_pool = c_cnt_w'(c_out_cols - 1);
  localparam logic [IN_WIDTH-1:0] c_sat       = IN_WIDTH'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);

  typedef enum logic [0:0] {
    ACC_FIRST  = 1'b0,
    ACC_SECOND = 1'b1
  } state_t;

  state_t               r_state, w_state_next;
  logic [c_cnt_w-1:0]   r_col_cnt, w_col_cnt_next;
  logic [IN_WIDTH-1:0]  r_hold   [c_out_rows];
  logic [IN_WIDTH-1:0]  w_pair   [c_out_rows];
  logic [OUT_WIDTH-1:0] w_result [c_out_rows];
  logic                 w_hold_load, w_new_result, w_frame_end, w_xfer;

  // After ReLU every value is non-negative, so unsigned compares suffice.
  for (genvar r = 0; r < c_out_rows; r++) begin : g_row
    logic [IN_WIDTH-1:0] w_lo, w_hi, w_max, w_scaled;
    assign w_lo        = in_data[2*r][IN_WIDTH-1]   ? '0 : in_data[2*r];
    assign w_hi        = in_data[2*r+1][IN_WIDTH-1] ? '0 : in_data[2*r+1];
    assign w_pair[r]   = (w_hi > w_lo) ? w_hi : w_lo;
    assign w_max       = (r_hold[r] > w_pair[r]) ? r_hold[r] : w_pair[r];
    assign w_scaled    = w_max >> FRAC_SHIFT;
    assign w_result[r] = (w_scaled > c_sat) ? c_sat[OUT_WIDTH-1:0] : w_scaled[OUT_WIDTH-1:0];
  end

  if (NUM_ROWS % 2 == 1) begin : g_odd_rows
    logic w_unused_row;
    assign w_unused_row = ^in_data[NUM_ROWS-1];
  end

  always_comb begin
    w_state_next   = r_state;
    w_col_cnt_next = r_col_cnt;
    w_hold_load    = 1'b0;
    w_new_result   = 1'b0;
    w_frame_end    = 1'b0;
    if (in_valid) begin
      w_frame_end    = (r_col_cnt == c_last_col);
      w_col_cnt_next = w_frame_end ? '0 : r_col_cnt + c_cnt_w'(1);
      case (r_state)
        // A trailing odd column has no partner and is dropped.
        ACC_FIRST: begin
          if (!w_frame_end) begin
            w_hold_load  = 1'b1;
            w_state_next = ACC_SECOND;
          end
        end
        ACC_SECOND: begin
          w_new_result = 1'b1;
          w_state_next = ACC_FIRST;
        end
        default: w_state_next = ACC_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACC_FIRST;
      r_col_cnt <= '0;
    end else if (clear) begin
      r_state   <= ACC_FIRST;
      r_col_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_col_cnt <= w_col_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < c_out_rows; r++) r_hold[r] <= '0;
    end else if (clear) begin
      for (int r = 0; r < c_out_rows; r++) r_hold[r] <= '0;
    end else if (w_hold_load) begin
      for (int r = 0; r < c_out_rows; r++) r_hold[r] <= w_pair[r];
    end
  end

  assign w_xfer = out_valid && out_ready;

  // Single-entry output register: a result arriving while it is stalled is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_col    <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int r = 0; r < c_out_rows; r++) out_data[r] <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_col    <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int r = 0; r < c_out_rows; r++) out_data[r] <= '0;
    end else begin
      frame_done <= w_frame_end;
      if (w_new_result) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_col   <= c_col_w'(r_col_cnt >> 1);
          out_last  <= ((r_col_cnt >> 1) == c_last_pool);
          for (int r = 0; r < c_out_rows; r++) out_data[r] <= w_result[r];
        end else begin
          overflow <= 1'b1;
        end
      end else if (w_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool_col.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool_col
// Brief    : Scoreboard bench for relu_maxpool_col with directed column vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool_col;
  localparam int IW = 32, OW = 16, NR = 25, NC = 25, FS = 8;
  localparam int OR = NR / 2, OC = NC / 2, CW = $clog2(OC) + 1;

  typedef struct packed {
    logic [OR*OW-1:0] d;
    logic [CW-1:0]    col;
    logic             last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, out_valid, out_ready, out_last, frame_done, overflow;
  logic [IW-1:0] in_data  [NR-1:0];
  logic [OW-1:0] out_data [OR-1:0];
  logic [CW-1:0] out_col;

  exp_t          q[$];
  exp_t          mon_e, e1, ex;
  int            n_total = 0, n_bad = 0, fd_cnt = 0, fd0;
  logic [IW-1:0] cur  [NR];
  logic [IW-1:0] prev [NR];

  always #5 clk = ~clk;

  relu_maxpool_col #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_ROWS(NR), .NUM_COLS(NC), .FRAC_SHIFT(FS)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
  );

  task automatic check(input string name, input logic [OR*OW-1:0] act, input logic [OR*OW-1:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [OR*OW-1:0] pack_out();
    logic [OR*OW-1:0] p;
    for (int r = 0; r < OR; r++) p[r*OW +: OW] = out_data[r];
    return p;
  endfunction

  // Reference: ReLU, 2x2 max over both columns, shift, clamp to OW-bit signed max.
  function automatic exp_t model(input logic [IW-1:0] a [NR], input logic [IW-1:0] b [NR], input int col);
    exp_t e;
    logic [IW-1:0] m, v [4];
    for (int r = 0; r < OR; r++) begin
      v[0] = a[2*r]; v[1] = a[2*r+1]; v[2] = b[2*r]; v[3] = b[2*r+1];
      m = '0;
      for (int k = 0; k < 4; k++) if (!v[k][IW-1] && v[k] > m) m = v[k];
      m = m >> FS;
      e.d[r*OW +: OW] = (m > 32'd32767) ? 16'h7FFF : m[OW-1:0];
    end
    e.col  = CW'(col);
    e.last = (col == OC - 1);
    return e;
  endfunction

  function automatic logic [IW-1:0] pat(input int c, input int r);
    if (r == c) return 32'h7FFF_0000;
    return IW'(((c * 37 + r * 53) % 211 - 60) * 4099);
  endfunction

  task automatic zero_cur();
    for (int r = 0; r < NR; r++) cur[r] = '0;
  endtask

  task automatic fill(input int c);
    for (int r = 0; r < NR; r++) cur[r] = pat(c, r);
  endtask

  task automatic step(input logic v);
    in_valid = v;
    for (int r = 0; r < NR; r++) in_data[r] = cur[r];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_row0(input logic [OW-1:0] d0, input int col);
    exp_t e;
    e.d = '0;
    e.d[OW-1:0] = d0;
    e.col  = CW'(col);
    e.last = 1'b0;
    q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, pack_out(), 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_fdone"}, frame_done, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  // Monitor: every accepted output is compared against the scoreboard front.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_output: got col %0d with no expected entry", out_col);
      end else begin
        mon_e = q.pop_front();
        check("mon_data", pack_out(), mon_e.d);
        check("mon_col", out_col, mon_e.col);
        check("mon_last", out_last, mon_e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    zero_cur();
    for (int r = 0; r < NR; r++) in_data[r] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic pair: negative row clipped, max of four is 0x500 -> 5.
    zero_cur(); cur[0] = 32'h0000_0300; cur[1] = 32'hFFFF_FF00;
    step(1);
    check("t1_no_early_valid", out_valid, 0);
    zero_cur(); cur[0] = 32'h0000_0100; cur[1] = 32'h0000_0500;
    push_row0(16'h0005, 0);
    step(1);
    check("t1_latency_valid", out_valid, 1);

    // Saturation, then an all-negative pair.
    zero_cur(); cur[0] = 32'h0100_0000;
    step(1);
    zero_cur();
    push_row0(16'h7FFF, 1);
    step(1);
    for (int r = 0; r < NR; r++) cur[r] = 32'hFFFF_0000 - IW'(r);
    step(1);
    push_row0(16'h0000, 2);
    step(1);
    clear = 1'b1; step(0); clear = 1'b0;

    // Full 25-column frame.
    fd0 = fd_cnt;
    for (int c = 0; c < NC; c++) begin
      fill(c);
      if (c % 2 == 1) q.push_back(model(prev, cur, c / 2));
      prev = cur;
      step(1);
      if (c == NC - 2) check("t3_fdone_early", frame_done, 0);
      if (c == NC - 1) begin
        check("t3_fdone_pulse", frame_done, 1);
        check("t3_trailing_no_output", out_valid, 0);
      end
    end
    step(0); step(0);
    check("t3_fdone_count", fd_cnt - fd0, 1);

    // Backpressure: first result held, second dropped.
    out_ready = 1'b0;
    fill(1); prev = cur; step(1);
    fill(2); e1 = model(prev, cur, 0); q.push_back(e1); step(1);
    check("t4_valid_first", out_valid, 1);
    fill(3); step(1);
    check("t4_no_ovf_yet", overflow, 0);
    fill(4); step(1);
    check("t4_overflow", overflow, 1);
    check("t4_hold_valid", out_valid, 1);
    check("t4_hold_data", pack_out(), e1.d);
    check("t4_hold_col", out_col, e1.col);
    out_ready = 1'b1;
    step(0);
    check("t4_valid_fall", out_valid, 0);
    check("t4_ovf_sticky", overflow, 1);
    clear = 1'b1; step(0); clear = 1'b0;
    check("t4_clear_ovf", overflow, 0);

    // Transfer and load in the same cycle.
    out_ready = 1'b0;
    fill(5); prev = cur; step(1);
    fill(6); q.push_back(model(prev, cur, 0)); step(1);
    fill(7); prev = cur; step(1);
    out_ready = 1'b1;
    fill(8); q.push_back(model(prev, cur, 1)); step(1);
    check("t5_valid_kept", out_valid, 1);
    check("t5_no_ovf", overflow, 0);
    check("t5_col", out_col, 1);
    step(0);

    // Asynchronous reset mid-frame.
    clear = 1'b1; step(0); clear = 1'b0;
    out_ready = 1'b0;
    fill(9); prev = cur; step(1);
    fill(10); q.push_back(model(prev, cur, 0)); step(1);
    fill(11); step(1);
    check("t6_pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_zero_outputs("t6_rst");
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    fill(12); prev = cur; step(1);
    fill(13); ex = model(prev, cur, 0); q.push_back(ex); step(1);
    check("t6_rst_newframe_col", out_col, 0);
    step(0);

    // Synchronous clear mid-frame, colliding with an in_valid column.
    out_ready = 1'b0;
    fill(14); prev = cur; step(1);
    fill(15); q.push_back(model(prev, cur, 0)); step(1);
    fill(16); step(1);
    fill(17); clear = 1'b1; step(1); clear = 1'b0;
    q.delete();
    check_zero_outputs("t6_clr");
    out_ready = 1'b1;
    fill(18); prev = cur; step(1);
    fill(19); q.push_back(model(prev, cur, 0)); step(1);
    check("t6_clr_newframe_col", out_col, 0);
    step(0); step(0);

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relu_maxpool_col.md
Name: relu_maxpool_col

Overview:
- Consumes the column-parallel convolution outputs produced by the conv_4 array controller.
- Each input column is one vector of NUM_ROWS signed accumulator words.
- Applies ReLU, then 2x2 stride-2 max pooling across consecutive column pairs, then rescales and saturates to OUT_WIDTH.
- Emits one pooled column per input column pair over a valid/ready interface toward the next layer buffer.

Parameters:
- IN_WIDTH, 32: signed width of each conv accumulator word.
- OUT_WIDTH, 16: signed width of each pooled output word.
- NUM_ROWS, 25: words per input column. Derived: OUT_ROWS = NUM_ROWS/2, floor.
- NUM_COLS, 25: columns per frame. Derived: OUT_COLS = NUM_COLS/2, floor.
- FRAC_SHIFT, 8: right shift applied after pooling, before saturation.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- clear, input, 1: synchronous frame abort.
- in_valid, input, 1: in_data holds a valid column this cycle. There is no backpressure on the input side.
- in_data, input, IN_WIDTH x [NUM_ROWS-1:0] unpacked: input column, signed.
- out_valid, output, 1: out_data holds a pooled column.
- out_ready, input, 1: consumer accepts out_data.
- out_data, output, OUT_WIDTH x [OUT_ROWS-1:0] unpacked: pooled column.
- out_col, output, $clog2(OUT_COLS)+1: index of the pooled column within the frame.
- out_last, output, 1: out_data is the final pooled column of the frame.
- frame_done, output, 1: one-cycle pulse when the frame's last input column has been consumed.
- overflow, output, 1: sticky flag; a pooled result was dropped because of backpressure.

Behaviour:
- Reset values: out_valid, out_data, out_col, out_last, frame_done, overflow are all 0. col_cnt = 0. State = ACC_FIRST. Hold registers = 0.
- rst mid-frame discards all partial state.
- clear has the same effect as rst, synchronously. clear has priority over in_valid in the same cycle.
- ReLU: a word with MSB = 1 becomes 0. After ReLU, all values are non-negative.
- Vertical pair: row r of a column pair uses input rows 2r and 2r+1. With odd NUM_ROWS, row NUM_ROWS-1 is ignored.
- Scaling: result = pooled >> FRAC_SHIFT (logical). If result > 2^(OUT_WIDTH-1)-1, output 2^(OUT_WIDTH-1)-1.
- ACC_FIRST state, on in_valid:
  - If col_cnt == NUM_COLS-1 (odd trailing column): discard the column, set col_cnt <= 0, pulse frame_done next cycle, stay in ACC_FIRST.
  - Otherwise: hold[r] <= max(relu(in[2r]), relu(in[2r+1])), col_cnt++, go to ACC_SECOND.
- ACC_SECOND state, on in_valid:
  - Result[r] = max(hold[r], relu(in[2r]), relu(in[2r+1])), then scaled.
  - Result is offered to the output register. col_cnt++, go to ACC_FIRST.
  - If col_cnt == NUM_COLS-1 (even NUM_COLS): col_cnt <= 0 and frame_done pulses next cycle.
- No in_valid: state and counters hold.
- Latency: out_valid rises on the cycle after the in_valid cycle of the second column of the pair.
- out_col = (col_cnt at the second column) / 2. out_last = 1 when out_col == OUT_COLS-1.
- Output register, single entry:
  - Transfer occurs when out_valid && out_ready.
  - After a transfer with no new result, out_valid <= 0.
  - New result with the register empty, or with a transfer in the same cycle: load the result, out_valid <= 1.
  - New result with out_valid=1 && !out_ready: keep the old data, drop the new result, set overflow <= 1 (sticky until rst or clear).
- out_data, out_col, out_last are stable while out_valid && !out_ready.
- frame_done is independent of output acceptance.

Test Plan:
1. Pair A={r0=0x00000300, r1=0xFFFFFF00}, B={r0=0x00000100, r1=0x00000500}, out_ready=1 -> out_data[0]=0x0005 one cycle after B's in_valid; out_col=0, out_last=0.
2. r0=0x01000000 in A, B all zero -> out_data[0]=0x7FFF (saturated); all-negative pair -> out_data[r]=0x0000.
3. Full frame of 25 columns, out_ready=1 -> 12 pooled columns, out_col 0..11, out_last only on 11. Column 24 produces no output; frame_done pulses once, one cycle after column 24.
4. out_ready=0 across 4 columns -> first result held unchanged; second dropped; overflow=1. Then out_ready=1 -> first result transfers, out_valid falls; overflow stays 1.
5. out_valid=1 with out_ready=1 in the same cycle a new result arrives -> old result transfers, new result loaded, out_valid stays 1, no overflow.
6. rst asserted after 3 columns -> all outputs 0 immediately. The next frame's first column is treated as col 0. Same check repeated with clear.
